// File: rtl/fp_arb_pkg.sv
// Op encodings, default unit latencies and reservation-pipe depth helper
// shared by the FP unit arbiter and its slot reservation pipe.
package fp_arb_pkg;

  typedef enum logic [1:0] {
    OP_DIV = 2'd0,
    OP_MUL = 2'd1,
    OP_SUB = 2'd2,
    OP_RSV = 2'd3
  } fp_op_e;

  localparam int DEF_DIV_LAT = 6;
  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_SUB_LAT = 7;

  // Pipe depth: the longest unit latency plus one lookahead slot for the eligibility check.
  function automatic int fp_maxl(input int div_lat, input int mul_lat, input int sub_lat);
    int mx;
    mx = div_lat;
    if (mul_lat > mx) mx = mul_lat;
    if (sub_lat > mx) mx = sub_lat;
    return mx + 1;
  endfunction

endpackage

// File: rtl/fp_slot_reservation.sv
// Result-bus slot pipe: bit k set means a result returns k cycles from now.
// Shifts every cycle; an insert lands at index ins_lat_i of the shifted pipe.
module fp_slot_reservation
  import fp_arb_pkg::*;
#(
  parameter int MAXL = 8,
  parameter int LW   = $clog2(MAXL + 1)
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic [1:0][LW-1:0] qry_lat_i,
  output logic [1:0]         qry_free_o,
  input  logic               ins_vld_i,
  input  logic [LW-1:0]      ins_lat_i,
  input  logic               ins_tag_i,
  input  fp_op_e             ins_op_i,
  output logic               head_vld_o,
  output logic               head_tag_o,
  output fp_op_e             head_op_o,
  output logic               any_vld_o
);

  logic [MAXL:0]      resv_q, resv_d;
  logic [MAXL:0]      tag_q, tag_d;
  logic [MAXL:0][1:0] op_q, op_d;

  always_comb begin
    resv_d = resv_q >> 1;
    tag_d  = tag_q >> 1;
    op_d   = op_q >> 2;
    for (int k = 0; k <= MAXL; k++) begin
      if (ins_vld_i && (ins_lat_i == LW'(k))) begin
        resv_d[k] = 1'b1;
        tag_d[k]  = ins_tag_i;
        op_d[k]   = ins_op_i;
      end
    end
  end

  // A slot at latency L is free when bit L+1 is clear, since that bit shifts into L this edge.
  always_comb begin
    qry_free_o = '1;
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < MAXL; k++) begin
        if ((qry_lat_i[j] == LW'(k)) && resv_q[k+1]) qry_free_o[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      resv_q <= '0;
      tag_q  <= '0;
      op_q   <= '0;
    end else begin
      resv_q <= resv_d;
      tag_q  <= tag_d;
      op_q   <= op_d;
    end
  end

  assign head_vld_o = resv_q[0];
  assign head_tag_o = tag_q[0];
  assign head_op_o  = fp_op_e'(op_q[0]);
  assign any_vld_o  = |resv_q;

endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares pipelined div/mul/sub units between two requesters; result L+1 cycles after fire.
// A requester stalls (ready low) until its unit's completion slot on the result bus is free.
module fp_unit_arbiter
  import fp_arb_pkg::*;
#(
  parameter int W       = 32,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int SUB_LAT = DEF_SUB_LAT
) (
  input  logic         clk,
  input  logic         program_reset,
  input  logic [1:0]   rq_valid,
  output logic [1:0]   rq_ready,
  input  logic [1:0]   rq0_op,
  input  logic [1:0]   rq1_op,
  input  logic [W-1:0] rq0_a,
  input  logic [W-1:0] rq0_b,
  input  logic [W-1:0] rq1_a,
  input  logic [W-1:0] rq1_b,
  output logic [W-1:0] divider_a,
  output logic [W-1:0] divider_b,
  output logic [W-1:0] multiplier_a,
  output logic [W-1:0] multiplier_b,
  output logic [W-1:0] subtractor_a,
  output logic [W-1:0] subtractor_b,
  input  logic [W-1:0] divider_r,
  input  logic [W-1:0] multiplier_r,
  input  logic [W-1:0] subtractor_r,
  output logic         res_valid,
  output logic         res_tag,
  output logic [1:0]   res_op,
  output logic [W-1:0] res_data,
  output logic         illegal_op,
  output logic         busy
);

  localparam int MAXL = fp_maxl(DIV_LAT, MUL_LAT, SUB_LAT);
  localparam int LW   = $clog2(MAXL + 1);

  function automatic logic [LW-1:0] lat_of(input fp_op_e op);
    case (op)
      OP_DIV:  return LW'(DIV_LAT);
      OP_MUL:  return LW'(MUL_LAT);
      OP_SUB:  return LW'(SUB_LAT);
      default: return '0;
    endcase
  endfunction

  fp_op_e             req_op [2];
  logic [1:0][LW-1:0] qry_lat;
  logic [1:0]         qry_free, elig, grant;
  logic               fire, rr_q, rr_d, illegal_q, illegal_d;
  fp_op_e             sel_op, head_op;
  logic [W-1:0]       sel_a, sel_b;
  logic [W-1:0]       div_a_q, div_a_d, div_b_q, div_b_d;
  logic [W-1:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [W-1:0]       sub_a_q, sub_a_d, sub_b_q, sub_b_d;
  logic               head_vld, head_tag, any_vld;

  assign req_op[0] = fp_op_e'(rq0_op);
  assign req_op[1] = fp_op_e'(rq1_op);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      qry_lat[i] = lat_of(req_op[i]);
      elig[i]    = rq_valid[i] && !program_reset && ((req_op[i] == OP_RSV) || qry_free[i]);
    end
  end

  // rr_q names the requester that wins when both are eligible.
  assign grant[0] = elig[0] && (!elig[1] || !rr_q);
  assign grant[1] = elig[1] && (!elig[0] ||  rr_q);
  assign rq_ready = grant;
  assign fire     = |grant;

  always_comb begin
    sel_op    = grant[1] ? req_op[1] : req_op[0];
    sel_a     = grant[1] ? rq1_a : rq0_a;
    sel_b     = grant[1] ? rq1_b : rq0_b;
    rr_d      = fire ? grant[0] : rr_q;
    illegal_d = fire && (sel_op == OP_RSV);
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    sub_a_d   = sub_a_q;
    sub_b_d   = sub_b_q;
    if (fire) begin
      case (sel_op)
        OP_DIV:  begin div_a_d = sel_a; div_b_d = sel_b; end
        OP_MUL:  begin mul_a_d = sel_a; mul_b_d = sel_b; end
        OP_SUB:  begin sub_a_d = sel_a; sub_b_d = sel_b; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (program_reset) begin
      rr_q      <= 1'b0;
      illegal_q <= 1'b0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      sub_a_q   <= '0;
      sub_b_q   <= '0;
    end else begin
      rr_q      <= rr_d;
      illegal_q <= illegal_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      sub_a_q   <= sub_a_d;
      sub_b_q   <= sub_b_d;
    end
  end

  fp_slot_reservation #(.MAXL(MAXL), .LW(LW)) u_resv (
    .clk        (clk),
    .rst_i      (program_reset),
    .qry_lat_i  (qry_lat),
    .qry_free_o (qry_free),
    .ins_vld_i  (fire && (sel_op != OP_RSV)),
    .ins_lat_i  (lat_of(sel_op)),
    .ins_tag_i  (grant[1]),
    .ins_op_i   (sel_op),
    .head_vld_o (head_vld),
    .head_tag_o (head_tag),
    .head_op_o  (head_op),
    .any_vld_o  (any_vld)
  );

  always_comb begin
    case (head_op)
      OP_DIV:  res_data = divider_r;
      OP_MUL:  res_data = multiplier_r;
      OP_SUB:  res_data = subtractor_r;
      default: res_data = '0;
    endcase
  end

  assign res_valid    = head_vld && !program_reset;
  assign res_tag      = head_tag;
  assign res_op       = head_op;
  assign illegal_op   = illegal_q;
  assign busy         = any_vld;
  assign divider_a    = div_a_q;
  assign divider_b    = div_b_q;
  assign multiplier_a = mul_a_q;
  assign multiplier_b = mul_b_q;
  assign subtractor_a = sub_a_q;
  assign subtractor_b = sub_b_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter with behavioural pipelined FP unit stand-ins.
module tb_fp_unit_arbiter;

  logic        clk;
  logic        program_reset;
  logic [1:0]  rq_valid, rq_ready, rq0_op, rq1_op;
  logic [31:0] rq0_a, rq0_b, rq1_a, rq1_b;
  logic [31:0] divider_a, divider_b, multiplier_a, multiplier_b, subtractor_a, subtractor_b;
  logic [31:0] divider_r, multiplier_r, subtractor_r, res_data;
  logic        res_valid, res_tag, illegal_op, busy;
  logic [1:0]  res_op;

  int nassert = 0;
  int nfail   = 0;
  int cyc     = 0;
  int t0, t1;

  typedef struct {
    int          c;
    logic        tg;
    logic [1:0]  op;
    logic [31:0] d;
  } res_t;
  res_t res_q[$];

  fp_unit_arbiter dut (
    .clk(clk), .program_reset(program_reset), .rq_valid(rq_valid), .rq_ready(rq_ready),
    .rq0_op(rq0_op), .rq1_op(rq1_op), .rq0_a(rq0_a), .rq0_b(rq0_b), .rq1_a(rq1_a), .rq1_b(rq1_b),
    .divider_a(divider_a), .divider_b(divider_b), .multiplier_a(multiplier_a),
    .multiplier_b(multiplier_b), .subtractor_a(subtractor_a), .subtractor_b(subtractor_b),
    .divider_r(divider_r), .multiplier_r(multiplier_r), .subtractor_r(subtractor_r),
    .res_valid(res_valid), .res_tag(res_tag), .res_op(res_op), .res_data(res_data),
    .illegal_op(illegal_op), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact results for the named vectors; a distinct mixing value per unit otherwise.
  function automatic logic [31:0] unit_fn(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b);
    if (k == 2'd1 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (k == 2'd0 && a == 32'h3F800000 && b == 32'h40800000) return 32'h3E800000;
    return (a ^ {b[15:0], b[31:16]}) + ({30'd0, k} * 32'h01010101);
  endfunction

  logic [31:0] div_p [6];
  logic [31:0] mul_p [5];
  logic [31:0] sub_p [7];
  always @(posedge clk) begin
    div_p[0] <= unit_fn(2'd0, divider_a, divider_b);
    mul_p[0] <= unit_fn(2'd1, multiplier_a, multiplier_b);
    sub_p[0] <= unit_fn(2'd2, subtractor_a, subtractor_b);
    for (int k = 1; k < 6; k++) div_p[k] <= div_p[k-1];
    for (int k = 1; k < 5; k++) mul_p[k] <= mul_p[k-1];
    for (int k = 1; k < 7; k++) sub_p[k] <= sub_p[k-1];
  end
  assign divider_r    = div_p[5];
  assign multiplier_r = mul_p[4];
  assign subtractor_r = sub_p[6];

  always @(negedge clk) if (res_valid) res_q.push_back('{cyc, res_tag, res_op, res_data});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string nm, input int idx, input int c, input logic tg,
                         input logic [1:0] op, input logic [31:0] d);
    chk({nm, "_present"}, 64'(idx < res_q.size()), 64'd1);
    if (idx < res_q.size()) begin
      chk({nm, "_cycle"}, 64'(res_q[idx].c), 64'(c));
      chk({nm, "_tag"},   64'(res_q[idx].tg), 64'(tg));
      chk({nm, "_op"},    64'(res_q[idx].op), 64'(op));
      chk({nm, "_data"},  64'(res_q[idx].d), 64'(d));
    end
  endtask

  initial begin
    program_reset = 1'b1;
    rq_valid = 2'b11; rq0_op = 2'd1; rq1_op = 2'd1;
    rq0_a = '0; rq0_b = '0; rq1_a = '0; rq1_b = '0;
    tick();
    #1 chk("rst_ready", 64'(rq_ready), 64'd0);
    tick();
    program_reset = 1'b0; rq_valid = 2'b00;
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_illegal", 64'(illegal_op), 64'd0);
    chk("rst_mul_a", 64'(multiplier_a), 64'd0);
    chk("rst_div_b", 64'(divider_b), 64'd0);

    // r0 MUL 2.0*3.0
    res_q.delete();
    rq_valid = 2'b01; rq0_op = 2'd1; rq0_a = 32'h40000000; rq0_b = 32'h40400000;
    #1 chk("t1_ready", 64'(rq_ready), 64'd1);
    t0 = cyc;
    tick(); rq_valid = 2'b00;
    #1;
    chk("t1_mul_a", 64'(multiplier_a), 64'h40000000);
    chk("t1_mul_b", 64'(multiplier_b), 64'h40400000);
    chk("t1_busy", 64'(busy), 64'd1);
    repeat (8) tick();
    chk("t1_count", 64'(res_q.size()), 64'd1);
    chk_res("t1", 0, t0 + 6, 1'b0, 2'd1, 32'h40C00000);

    // r0 SUB, then r1 MUL collides on the result slot and stalls one cycle
    res_q.delete();
    rq_valid = 2'b01; rq0_op = 2'd2; rq0_a = 32'h41200000; rq0_b = 32'h3F800000;
    #1 chk("t2_sub_ready", 64'(rq_ready), 64'd1);
    t0 = cyc;
    tick(); rq_valid = 2'b00;
    tick(); rq_valid = 2'b10; rq1_op = 2'd1; rq1_a = 32'h40A00000; rq1_b = 32'h40E00000;
    #1 chk("t2_stall", 64'(rq_ready), 64'd0);
    tick();
    #1 chk("t2_grant", 64'(rq_ready), 64'd2);
    tick(); rq_valid = 2'b00;
    repeat (8) tick();
    chk("t2_count", 64'(res_q.size()), 64'd2);
    chk_res("t2_sub", 0, t0 + 8, 1'b0, 2'd2, unit_fn(2'd2, 32'h41200000, 32'h3F800000));
    chk_res("t2_mul", 1, t0 + 9, 1'b1, 2'd1, unit_fn(2'd1, 32'h40A00000, 32'h40E00000));

    // Both requesters stream MUL: round-robin alternation, one result per cycle
    res_q.delete();
    rq_valid = 2'b11; rq0_op = 2'd1; rq1_op = 2'd1;
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      rq0_a = 32'h3F800000 + i; rq0_b = 32'h40000000 + i;
      rq1_a = 32'h40400000 + i; rq1_b = 32'h40800000 + i;
      #1 chk("t3_grant", 64'(rq_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
      tick();
    end
    rq_valid = 2'b00;
    repeat (10) tick();
    chk("t3_count", 64'(res_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        chk_res("t3_r0", i, t0 + i + 6, 1'b0, 2'd1, unit_fn(2'd1, 32'h3F800000 + i, 32'h40000000 + i));
      else
        chk_res("t3_r1", i, t0 + i + 6, 1'b1, 2'd1, unit_fn(2'd1, 32'h40400000 + i, 32'h40800000 + i));
    end

    // r1 DIV 1.0/4.0 with busy window
    res_q.delete();
    rq_valid = 2'b10; rq1_op = 2'd0; rq1_a = 32'h3F800000; rq1_b = 32'h40800000;
    #1;
    chk("t4_ready", 64'(rq_ready), 64'd2);
    chk("t4_busy_t0", 64'(busy), 64'd0);
    t0 = cyc;
    tick(); rq_valid = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      #1 chk("t4_busy", 64'(busy), (k <= 7) ? 64'd1 : 64'd0);
      tick();
    end
    chk("t4_count", 64'(res_q.size()), 64'd1);
    chk_res("t4", 0, t0 + 7, 1'b1, 2'd0, 32'h3E800000);

    // Three ops in flight, then reset: none complete and the pointer returns to r0
    res_q.delete();
    rq_valid = 2'b01; rq0_op = 2'd0; rq0_a = 32'h11111111; rq0_b = 32'h22222222;
    #1 chk("t5_div_ready", 64'(rq_ready), 64'd1);
    tick(); rq_valid = 2'b10; rq1_op = 2'd2; rq1_a = 32'h33333333; rq1_b = 32'h44444444;
    #1 chk("t5_sub_ready", 64'(rq_ready), 64'd2);
    tick(); rq_valid = 2'b01; rq0_op = 2'd1; rq0_a = 32'h55555555; rq0_b = 32'h66666666;
    #1 chk("t5_mul_ready", 64'(rq_ready), 64'd1);
    tick();
    program_reset = 1'b1; rq_valid = 2'b11; rq0_op = 2'd1; rq1_op = 2'd1;
    rq0_a = 32'h3F800000; rq0_b = 32'h3F800000; rq1_a = 32'h40000000; rq1_b = 32'h40000000;
    #1;
    chk("t5_busy_pre", 64'(busy), 64'd1);
    chk("t5_rst_ready", 64'(rq_ready), 64'd0);
    tick(); program_reset = 1'b0;
    #1;
    chk("t5_busy_post", 64'(busy), 64'd0);
    chk("t5_rr_reset", 64'(rq_ready), 64'd1);
    t1 = cyc;
    tick(); rq_valid = 2'b00;
    repeat (10) tick();
    chk("t5_count", 64'(res_q.size()), 64'd1);
    chk_res("t5_post", 0, t1 + 6, 1'b0, 2'd1, unit_fn(2'd1, 32'h3F800000, 32'h3F800000));

    // Reserved op: accepted, flagged, nothing issued
    res_q.delete();
    rq_valid = 2'b01; rq0_op = 2'd3; rq0_a = 32'hAAAAAAAA; rq0_b = 32'hBBBBBBBB;
    #1;
    chk("t6_ready", 64'(rq_ready), 64'd1);
    chk("t6_illegal_t0", 64'(illegal_op), 64'd0);
    tick(); rq_valid = 2'b00;
    #1;
    chk("t6_illegal_t1", 64'(illegal_op), 64'd1);
    chk("t6_busy_t1", 64'(busy), 64'd0);
    tick();
    #1;
    chk("t6_illegal_t2", 64'(illegal_op), 64'd0);
    chk("t6_busy_t2", 64'(busy), 64'd0);
    repeat (8) tick();
    chk("t6_count", 64'(res_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
